// File: rtl/hus_wdma.sv
// Word DMA: reads 16-bit words from DRAM one request at a time and pushes them into a sample FIFO.
// Optional feature macro: HUS_WDMA_LOOP_EN (restart from loop_addr/loop_len at the end of each pass).
module hus_wdma (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic [20:0] addr_start,
   input  logic [15:0] length,
   input  logic [20:0] loop_addr,
   input  logic [15:0] loop_len,
   output logic        dram_req,
   output logic [20:0] dram_addr,
   input  logic        dram_next,
   input  logic        dram_stb,
   input  logic [15:0] dram_rdata,
   input  logic        fifo_full,
   output logic        fifo_we,
   output logic [15:0] fifo_wdata,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [20:0] addr_q, addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic        dram_req_q, dram_req_d;
   logic [20:0] dram_addr_q, dram_addr_d;
   logic        fifo_we_q, fifo_we_d;
   logic [15:0] fifo_wdata_q, fifo_wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

`ifndef HUS_WDMA_LOOP_EN
   logic        unused_loop_s;
   assign unused_loop_s = ^{loop_addr, loop_len};
`endif

   // Next-state and next-output computation for the transfer sequencer.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      dram_req_d   = dram_req_q;
      dram_addr_d  = dram_addr_q;
      fifo_we_d    = 1'b0;
      fifo_wdata_d = fifo_wdata_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            dram_req_d = 1'b0;
            if (start) begin
               addr_d = addr_start;
               cnt_d  = length;
               if (length == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_FILL: begin
            if (stop) begin
               // An acceptance in the abort cycle still leaves one read in flight.
               dram_req_d = 1'b0;
               if (dram_req_q && dram_next) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (dram_req_q) begin
               if (dram_next) begin
                  dram_req_d = 1'b0;
                  state_d    = S_WAIT;
               end else begin
                  dram_req_d = 1'b1;
               end
            end else begin
               dram_req_d  = ~fifo_full;
               dram_addr_d = addr_q;
            end
         end

         S_WAIT: begin
            if (dram_stb) begin
               if (stop) begin
                  state_d = S_IDLE;
               end else begin
                  fifo_we_d    = 1'b1;
                  fifo_wdata_d = dram_rdata;
                  addr_d       = addr_q + 21'd1;
                  cnt_d        = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     done_d = 1'b1;
`ifdef HUS_WDMA_LOOP_EN
                     if (loop_len != 16'd0) begin
                        addr_d  = loop_addr;
                        cnt_d   = loop_len;
                        state_d = S_FILL;
                     end else begin
                        state_d = S_IDLE;
                     end
`else
                     state_d = S_IDLE;
`endif
                  end else begin
                     state_d = S_FILL;
                  end
               end
            end else if (stop) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_DRAIN: begin
            if (dram_stb) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN;
            end
         end

         default: begin
            state_d    = S_IDLE;
            dram_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= 21'd0;
         cnt_q        <= 16'd0;
         dram_req_q   <= 1'b0;
         dram_addr_q  <= 21'd0;
         fifo_we_q    <= 1'b0;
         fifo_wdata_q <= 16'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         dram_req_q   <= dram_req_d;
         dram_addr_q  <= dram_addr_d;
         fifo_we_q    <= fifo_we_d;
         fifo_wdata_q <= fifo_wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign dram_req   = dram_req_q;
   assign dram_addr  = dram_addr_q;
   assign fifo_we    = fifo_we_q;
   assign fifo_wdata = fifo_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_hus_wdma.sv
// Scoreboard bench for hus_wdma: a DRAM responder returns queued words, observed traffic is
// checked against expectations pushed when each transfer is started.
module tb_hus_wdma;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, stop;
   logic [20:0] addr_start, loop_addr;
   logic [15:0] length, loop_len;
   logic        dram_req;
   logic [20:0] dram_addr;
   logic        dram_next, dram_stb;
   logic [15:0] dram_rdata;
   logic        fifo_full, fifo_we;
   logic [15:0] fifo_wdata;
   logic        busy, done;

   int vectors = 0;
   int miscompares = 0;

   logic [20:0] exp_addr_q[$], obs_addr_q[$];
   logic [15:0] exp_data_q[$], obs_data_q[$], rd_data_q[$];
   int done_cnt, done_with_we, stb_ctr;
   int stb_lat = 1;

   hus_wdma dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .addr_start(addr_start), .length(length),
      .loop_addr(loop_addr), .loop_len(loop_len),
      .dram_req(dram_req), .dram_addr(dram_addr),
      .dram_next(dram_next), .dram_stb(dram_stb), .dram_rdata(dram_rdata),
      .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // One clock: record DUT activity, then let the DRAM model react for the next edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (fifo_we === 1'b1) obs_data_q.push_back(fifo_wdata);
      if (done === 1'b1) begin
         done_cnt++;
         if (fifo_we === 1'b1) done_with_we++;
      end
      dram_stb = 1'b0;
      if (dram_next) begin
         dram_next = 1'b0;
         stb_ctr   = stb_lat;
      end else if (stb_ctr > 0) begin
         stb_ctr--;
         if (stb_ctr == 0) begin
            dram_stb = 1'b1;
            if (rd_data_q.size() > 0) dram_rdata = rd_data_q.pop_front();
            else dram_rdata = 16'h0000;
         end
      end else if (dram_req === 1'b1) begin
         obs_addr_q.push_back(dram_addr);
         dram_next = 1'b1;
      end
   endtask

   task automatic clear_sb();
      exp_addr_q.delete(); obs_addr_q.delete();
      exp_data_q.delete(); obs_data_q.delete(); rd_data_q.delete();
      done_cnt = 0; done_with_we = 0;
   endtask

   task automatic push_xfer(input logic [20:0] a, input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         logic [20:0] ai;
         ai = a + 21'(i);
         exp_addr_q.push_back(ai);
         exp_data_q.push_back(base + 16'(i));
         rd_data_q.push_back(base + 16'(i));
      end
   endtask

   task automatic pulse_start(input logic [20:0] a, input logic [15:0] n);
      start = 1'b1; addr_start = a; length = n;
      cycle();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; addr_start = 21'd0; length = 16'd0;
      loop_addr = 21'd0; loop_len = 16'd0; dram_next = 1'b0; dram_stb = 1'b0;
      dram_rdata = 16'h0; fifo_full = 1'b0; stb_ctr = 0;
      clear_sb();
      #12;
      vectors++;
      if ({dram_req, dram_addr, fifo_we, fifo_wdata, busy, done} !== 41'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", {dram_req, dram_addr, fifo_we, fifo_wdata, busy, done});
      end
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic test_basic();
      logic [20:0] ea, oa;
      logic [15:0] ed, od;
      clear_sb();
      push_xfer(21'h00100, 3, 16'h00A1);
      pulse_start(21'h00100, 16'd3);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
      for (int i = 0; i < 100 && busy === 1'b1; i++) cycle();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: busy %b want 0", busy); end
      vectors++;
      if (done_cnt != 1 || done_with_we != 1) begin
         miscompares++; $display("FAIL basic_done: got %0d/%0d want 1/1", done_cnt, done_with_we);
      end
      vectors++;
      if (obs_addr_q.size() != exp_addr_q.size() || obs_data_q.size() != exp_data_q.size()) begin
         miscompares++;
         $display("FAIL basic_count: addr %0d want %0d, data %0d want %0d",
                  obs_addr_q.size(), exp_addr_q.size(), obs_data_q.size(), exp_data_q.size());
      end
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); vectors++;
         if (oa !== ea) begin miscompares++; $display("FAIL basic_addr: got %h want %h", oa, ea); end
      end
      while (exp_data_q.size() > 0 && obs_data_q.size() > 0) begin
         ed = exp_data_q.pop_front(); od = obs_data_q.pop_front(); vectors++;
         if (od !== ed) begin miscompares++; $display("FAIL basic_data: got %h want %h", od, ed); end
      end
   endtask

   task automatic test_backpressure();
      int bp_bad;
      logic [20:0] ea, oa;
      logic [15:0] ed, od;
      clear_sb();
      bp_bad = 0;
      fifo_full = 1'b1;
      push_xfer(21'h00300, 2, 16'h3300);
      pulse_start(21'h00300, 16'd2);
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (dram_req !== 1'b0 || busy !== 1'b1) bp_bad++;
      end
      vectors++;
      if (bp_bad != 0) begin miscompares++; $display("FAIL bp_hold: %0d bad cycles want 0", bp_bad); end
      fifo_full = 1'b0;
      cycle();
      vectors++;
      if (dram_req !== 1'b1) begin miscompares++; $display("FAIL bp_release: dram_req %b want 1", dram_req); end
      for (int i = 0; i < 100 && busy === 1'b1; i++) cycle();
      vectors++;
      if (busy !== 1'b0 || done_cnt != 1) begin
         miscompares++; $display("FAIL bp_end: busy %b done %0d want 0/1", busy, done_cnt);
      end
      vectors++;
      if (obs_addr_q.size() != 2 || obs_data_q.size() != 2) begin
         miscompares++; $display("FAIL bp_count: addr %0d data %0d want 2/2", obs_addr_q.size(), obs_data_q.size());
      end
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); vectors++;
         if (oa !== ea) begin miscompares++; $display("FAIL bp_addr: got %h want %h", oa, ea); end
      end
      while (exp_data_q.size() > 0 && obs_data_q.size() > 0) begin
         ed = exp_data_q.pop_front(); od = obs_data_q.pop_front(); vectors++;
         if (od !== ed) begin miscompares++; $display("FAIL bp_data: got %h want %h", od, ed); end
      end
   endtask

   task automatic test_abort_wait();
      logic [20:0] oa;
      logic [15:0] od;
      clear_sb();
      stb_lat = 5;
      rd_data_q.push_back(16'hBEEF);
      pulse_start(21'h00400, 16'd4);
      for (int i = 0; i < 20 && stb_ctr == 0; i++) cycle();
      vectors++;
      if (stb_ctr == 0) begin miscompares++; $display("FAIL abw_accept: no request accepted"); end
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL abw_drain_busy: got %b want 1", busy); end
      for (int i = 0; i < 20 && dram_stb === 1'b0; i++) cycle();
      vectors++;
      if (dram_stb !== 1'b1) begin miscompares++; $display("FAIL abw_stb: strobe never issued"); end
      cycle();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL abw_idle: busy %b want 0", busy); end
      for (int i = 0; i < 3; i++) cycle();
      vectors++;
      if (obs_data_q.size() != 0 || done_cnt != 0) begin
         miscompares++; $display("FAIL abw_discard: writes %0d done %0d want 0/0", obs_data_q.size(), done_cnt);
      end
      vectors++;
      if (obs_addr_q.size() != 1) begin
         miscompares++; $display("FAIL abw_addr_count: got %0d want 1", obs_addr_q.size());
      end else begin
         oa = obs_addr_q.pop_front();
         if (oa !== 21'h00400) begin miscompares++; $display("FAIL abw_addr: got %h want 00400", oa); end
      end
      clear_sb();
      stb_lat = 1;
      push_xfer(21'h00010, 1, 16'h1010);
      pulse_start(21'h00010, 16'd1);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL abw_restart: busy %b want 1", busy); end
      for (int i = 0; i < 50 && busy === 1'b1; i++) cycle();
      vectors++;
      if (obs_data_q.size() != 1 || done_cnt != 1) begin
         miscompares++; $display("FAIL abw_restart_end: writes %0d done %0d want 1/1", obs_data_q.size(), done_cnt);
      end else begin
         od = obs_data_q.pop_front();
         if (od !== 16'h1010) begin miscompares++; $display("FAIL abw_restart_data: got %h want 1010", od); end
      end
   endtask

   task automatic test_edges();
      logic [20:0] ea, oa;
      clear_sb();
      pulse_start(21'h00900, 16'd0);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || dram_req !== 1'b0) begin
         miscompares++; $display("FAIL len0: done %b busy %b req %b want 1/0/0", done, busy, dram_req);
      end
      for (int i = 0; i < 4; i++) cycle();
      vectors++;
      if (done_cnt != 1 || obs_addr_q.size() != 0) begin
         miscompares++; $display("FAIL len0_after: done %0d reqs %0d want 1/0", done_cnt, obs_addr_q.size());
      end
      clear_sb();
      push_xfer(21'h1FFFFF, 2, 16'h1234);
      pulse_start(21'h1FFFFF, 16'd2);
      for (int i = 0; i < 100 && busy === 1'b1; i++) cycle();
      vectors++;
      if (obs_addr_q.size() != 2 || obs_data_q.size() != 2 || done_cnt != 1) begin
         miscompares++; $display("FAIL wrap_count: reqs %0d writes %0d done %0d want 2/2/1",
                                 obs_addr_q.size(), obs_data_q.size(), done_cnt);
      end
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); vectors++;
         if (oa !== ea) begin miscompares++; $display("FAIL wrap_addr: got %h want %h", oa, ea); end
      end
   endtask

   task automatic test_start_stop_ctl();
      logic [20:0] ea, oa;
      clear_sb();
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL stop_idle: busy %b done %b", busy, done); end
      push_xfer(21'h00600, 1, 16'h6600);
      stop = 1'b1;
      pulse_start(21'h00600, 16'd1);
      stop = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL start_wins: busy %b want 1", busy); end
      for (int i = 0; i < 50 && busy === 1'b1; i++) cycle();
      push_xfer(21'h00500, 2, 16'h5500);
      pulse_start(21'h00500, 16'd2);
      cycle(); cycle();
      pulse_start(21'h00700, 16'd5);
      for (int i = 0; i < 100 && busy === 1'b1; i++) cycle();
      vectors++;
      if (done_cnt != 2 || obs_addr_q.size() != 3 || obs_data_q.size() != 3) begin
         miscompares++; $display("FAIL start_busy: done %0d reqs %0d writes %0d want 2/3/3",
                                 done_cnt, obs_addr_q.size(), obs_data_q.size());
      end
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); vectors++;
         if (oa !== ea) begin miscompares++; $display("FAIL start_busy_addr: got %h want %h", oa, ea); end
      end
      clear_sb();
      fifo_full = 1'b1;
      pulse_start(21'h00A00, 16'd3);
      cycle(); cycle(); cycle();
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      fifo_full = 1'b0;
      vectors++;
      if (busy !== 1'b0 || dram_req !== 1'b0) begin
         miscompares++; $display("FAIL abort_fill: busy %b req %b want 0/0", busy, dram_req);
      end
      for (int i = 0; i < 4; i++) cycle();
      vectors++;
      if (obs_addr_q.size() != 0 || done_cnt != 0) begin
         miscompares++; $display("FAIL abort_fill_after: reqs %0d done %0d want 0/0", obs_addr_q.size(), done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      clear_sb();
      stb_lat = 3;
      rd_data_q.push_back(16'hDEAD);
      pulse_start(21'h00800, 16'd2);
      for (int i = 0; i < 20 && stb_ctr == 0; i++) cycle();
      #1 reset_n = 1'b0;
      #1;
      vectors++;
      if ({dram_req, dram_addr, fifo_we, fifo_wdata, busy, done} !== 41'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got %h want 0", {dram_req, dram_addr, fifo_we, fifo_wdata, busy, done});
      end
      cycle();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      vectors++;
      if (obs_data_q.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_stb: writes %0d done %0d busy %b want 0/0/0",
                                 obs_data_q.size(), done_cnt, busy);
      end
      stb_lat = 1;
   endtask

`ifdef HUS_WDMA_LOOP_EN
   task automatic test_loop();
      logic [20:0] ea, oa;
      logic [15:0] ed, od;
      clear_sb();
      loop_addr = 21'h00200; loop_len = 16'd1;
      exp_addr_q = '{21'h000FF, 21'h00100, 21'h00200, 21'h00200, 21'h00200};
      for (int i = 0; i < 5; i++) begin
         exp_data_q.push_back(16'hC000 + 16'(i));
         rd_data_q.push_back(16'hC000 + 16'(i));
      end
      pulse_start(21'h000FF, 16'd2);
      for (int i = 0; i < 200 && obs_data_q.size() < 5; i++) cycle();
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      vectors++;
      if (busy !== 1'b0 || done_cnt != 4 || done_with_we != 4) begin
         miscompares++; $display("FAIL loop_done: busy %b done %0d/%0d want 0 4/4", busy, done_cnt, done_with_we);
      end
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
         ea = exp_addr_q.pop_front(); oa = obs_addr_q.pop_front(); vectors++;
         if (oa !== ea) begin miscompares++; $display("FAIL loop_addr: got %h want %h", oa, ea); end
      end
      while (exp_data_q.size() > 0 && obs_data_q.size() > 0) begin
         ed = exp_data_q.pop_front(); od = obs_data_q.pop_front(); vectors++;
         if (od !== ed) begin miscompares++; $display("FAIL loop_data: got %h want %h", od, ed); end
      end
      loop_addr = 21'd0; loop_len = 16'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_abort_wait();
      test_edges();
      test_start_stop_ctl();
      test_reset_mid();
`ifdef HUS_WDMA_LOOP_EN
      test_loop();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hus_wdma.md
HUS_WDMA -- requirements
Module: hus_wdma

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse; begin transfer; ignored while busy.
REQ-004 SHALL have ports: stop  in  1  one-cycle pulse; abort transfer.
REQ-005 SHALL have ports: addr_start  in  21  first word address.
REQ-006 SHALL have ports: length  in  16  transfer length in 16-bit words.
REQ-007 SHALL have ports: loop_addr  in  21, loop_len  in  16  loop restart address and length (used only under HUS_WDMA_LOOP_EN).
REQ-008 SHALL have ports: dram_req  out  1, dram_addr  out  21  read request and word address.
REQ-009 SHALL have ports: dram_next  in  1  request accepted; dram_stb  in  1  read data valid; dram_rdata  in  16  read data.
REQ-010 SHALL have ports: fifo_full  in  1, fifo_we  out  1, fifo_wdata  out  16  sample FIFO write side.
REQ-011 SHALL have ports: busy  out  1  transfer active; done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, FILL, WAIT, DRAIN; busy=1 in all states except IDLE.
REQ-013 IDLE: on start, SHALL latch addr_start into address counter and length into word counter. length=0 -> done pulse next cycle, remain IDLE, no dram_req. Otherwise -> FILL.
REQ-014 FILL: SHALL assert dram_req, dram_addr = address counter, only while fifo_full=0. fifo_full=1 -> dram_req=0, stay FILL.
REQ-015 Once asserted, dram_req and dram_addr SHALL hold stable until the cycle dram_next=1, then -> WAIT with dram_req=0 next cycle.
REQ-016 At most one outstanding read SHALL exist; dram_stb outside WAIT/DRAIN SHALL be ignored.
REQ-017 WAIT: on dram_stb, SHALL register dram_rdata into fifo_wdata and pulse fifo_we for exactly one cycle, one cycle after dram_stb. On the same edge, address +1 (21-bit, wraps 1FFFFF->000000) and word counter -1.
REQ-018 Word counter 1 -> 0 on dram_stb: SHALL pulse done in the fifo_we cycle and enter IDLE, unless looping (REQ-025). Otherwise -> FILL.
REQ-019 stop in FILL SHALL drop dram_req the next cycle and go IDLE, unless dram_next=1 in that same cycle; then -> DRAIN.
REQ-020 stop in WAIT SHALL go to DRAIN. DRAIN SHALL consume the pending dram_stb without fifo_we, then go IDLE.
REQ-021 stop SHALL never produce done. stop in IDLE SHALL be ignored. stop has priority over completion in the same cycle: data is discarded and there is no done.
REQ-022 start while busy SHALL be ignored. Simultaneous start and stop in IDLE: start wins.

Reset
REQ-023 reset_n low SHALL force immediately, including mid-transfer, state=IDLE and dram_req=0, dram_addr=0, fifo_we=0, fifo_wdata=0, busy=0, done=0, with counters cleared.
REQ-024 An outstanding read interrupted by reset SHALL have its later dram_stb ignored.

Configuration
REQ-025 With HUS_WDMA_LOOP_EN defined: at word counter 1 -> 0, SHALL reload address from loop_addr and counter from loop_len and continue in FILL.
  - done still pulses once per wrap.
  - loop_len=0 -> terminate to IDLE, no second done.
REQ-026 Without HUS_WDMA_LOOP_EN: transfer SHALL always end at word counter 0.
  - loop_addr and loop_len unused.
  - No loop logic synthesised.

Verification
REQ-027 Basic transfer: start, addr_start=0x00100, length=3, dram_next immediate, dram_stb 2 cycles later, data A1,A2,A3.
  -> addresses 0x00100..0x00102 in order.
  -> three fifo_we pulses carrying A1,A2,A3.
  -> one done pulse with the third write, then busy=0.
REQ-028 Backpressure: fifo_full=1 held 10 cycles in FILL -> dram_req=0 throughout. Release -> dram_req next cycle, no lost or duplicated word.
REQ-029 Abort in WAIT: stop while a read is outstanding, then dram_stb with 0xBEEF.
  -> no fifo_we, no done.
  -> busy=0 the cycle after dram_stb.
  -> new start accepted next.
REQ-030 Edge cases:
  - length=0 -> done pulse, no dram_req.
  - addr_start=0x1FFFFF, length=2 -> addresses 0x1FFFFF then 0x000000.
REQ-031 Reset mid-transfer: reset_n low in WAIT -> all outputs 0 immediately; later dram_stb -> no fifo_we.
REQ-032 HUS_WDMA_LOOP_EN: length=2, loop_addr=0x00200, loop_len=1 -> addresses X, X+1, 0x00200, 0x00200, ... with done at each wrap until stop.
